// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one countdown timer among four requesters.
// Optional abort support (cancel port) is enabled by defining TIMER_SCHED_ABORT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate when any req is high
// LOAD  | grant owner, strobe timer_start with the latched duration
// RUN   | owner holds the timer; wait for timer_expired
// DONE  | pulse done to owner, release grant, remember owner for round-robin
module timer_scheduler (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [23:0] duration,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy,
    output logic        timer_start,
    output logic [5:0]  timer_param,
    input  logic        timer_expired
`ifdef TIMER_SCHED_ABORT_EN
    ,
    input  logic [3:0]  cancel
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [1:0]  last_granted;
    logic [1:0]  winner;
    logic [5:0]  winner_dur;
    logic        abort;

    // Lowest offset from last_granted+1 wins; descending loop lets it overwrite.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] c;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            c = last + 2'(k);
            if (r[c]) rr_pick = c;
        end
    endfunction

    always_comb begin
        winner     = rr_pick(req, last_granted);
        winner_dur = duration[6*winner +: 6];
    end

`ifdef TIMER_SCHED_ABORT_EN
    always_comb abort = cancel[idx];
`else
    always_comb abort = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= 2'd0;
            last_granted <= 2'd3;
            grant        <= 4'b0000;
            done         <= 4'b0000;
            busy         <= 1'b0;
            timer_start  <= 1'b0;
            timer_param  <= 6'd0;
        end else begin
            timer_start <= 1'b0;
            done        <= 4'b0000;
            case (state)
                IDLE: begin
                    if (|req) begin
                        idx         <= winner;
                        timer_param <= winner_dur;
                        timer_start <= 1'b1;
                        grant       <= 4'b0001 << winner;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        grant        <= 4'b0000;
                        busy         <= 1'b0;
                        last_granted <= idx;
                        state        <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Abort takes priority over a simultaneous expiry.
                    if (abort) begin
                        grant        <= 4'b0000;
                        busy         <= 1'b0;
                        last_granted <= idx;
                        state        <= IDLE;
                    end else if (timer_expired) begin
                        grant <= 4'b0000;
                        done  <= 4'b0001 << idx;
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_granted <= idx;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
